mem_2_to_1_arbiter: RTL

- Round-robin arbiter that sits directly upstream of the two-region single-port memory wrapper.
- Accepts read/write requests from two independent clients (e.g. two isogeny-step engines) and issues at most one access per cycle on the wrapper's mem_0_* or mem_1_* port.
- Returns read data, tagged by client, one cycle later; supports lock-hold bursts and flags out-of-range addresses.

---
 rtl/mem_2_to_1_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_2_to_1_arbiter.sv
// Round-robin arbiter that feeds two clients into the two-region single-port memory wrapper.
// Define MEM_ARB_STATS_EN to add saturating grant/conflict counters (stat_* ports).
module mem_2_to_1_arbiter #(
    parameter int WIDTH                = 32,
    parameter int SINGLE_MEM_DEPTH     = 14,
    parameter int SINGLE_MEM_DEPTH_LOG = $clog2(SINGLE_MEM_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            c0_req,
    input  logic                            c0_we,
    input  logic                            c0_lock,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] c0_addr,
    input  logic [WIDTH-1:0]                c0_din,
    output logic                            c0_gnt,
    output logic                            c0_rvalid,
    output logic [WIDTH-1:0]                c0_rdata,
    input  logic                            c1_req,
    input  logic                            c1_we,
    input  logic                            c1_lock,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] c1_addr,
    input  logic [WIDTH-1:0]                c1_din,
    output logic                            c1_gnt,
    output logic                            c1_rvalid,
    output logic [WIDTH-1:0]                c1_rdata,
    output logic                            mem_0_wr_en,
    output logic                            mem_0_rd_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_wr_addr,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_rd_addr,
    output logic [WIDTH-1:0]                mem_0_din,
    output logic                            mem_1_wr_en,
    output logic                            mem_1_rd_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_wr_addr,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_rd_addr,
    output logic [WIDTH-1:0]                mem_1_din,
    input  logic [WIDTH-1:0]                mem_dout,
    output logic                            addr_err
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]                     stat_gnt0,
    output logic [31:0]                     stat_gnt1,
    output logic [31:0]                     stat_conflict
`endif
);

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_C0   = 2'd1,
        LOCK_C1   = 2'd2
    } lockOwner_t;

    // One extra bit so a power-of-two depth is still representable.
    localparam logic [SINGLE_MEM_DEPTH_LOG:0] DEPTH_W = (SINGLE_MEM_DEPTH_LOG + 1)'(SINGLE_MEM_DEPTH);

    lockOwner_t lockOwner_q, lockOwner_d;
    logic       lastGnt_q, lastGnt_d;
    logic       rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic       rdErr0_q, rdErr0_d, rdErr1_q, rdErr1_d;
    logic       addrErr_q, addrErr_d;
    logic       inRange0, inRange1, sel0, sel1;

    assign inRange0 = {1'b0, c0_addr} < DEPTH_W;
    assign inRange1 = {1'b0, c1_addr} < DEPTH_W;

    always_comb begin
        c0_gnt = 1'b0;
        c1_gnt = 1'b0;
        if (!rst) begin
            if (lockOwner_q == LOCK_C0 && c0_req) begin
                c0_gnt = 1'b1;
            end else if (lockOwner_q == LOCK_C1 && c1_req) begin
                c1_gnt = 1'b1;
            end else if (c0_req && c1_req) begin
                c0_gnt = lastGnt_q;
                c1_gnt = ~lastGnt_q;
            end else begin
                c0_gnt = c0_req;
                c1_gnt = c1_req;
            end
        end
    end

    // A lock only survives while its owner keeps being granted with lock asserted.
    always_comb begin
        lockOwner_d = LOCK_NONE;
        lastGnt_d   = lastGnt_q;
        if (c0_gnt) begin
            lastGnt_d   = 1'b0;
            lockOwner_d = c0_lock ? LOCK_C0 : LOCK_NONE;
        end else if (c1_gnt) begin
            lastGnt_d   = 1'b1;
            lockOwner_d = c1_lock ? LOCK_C1 : LOCK_NONE;
        end
        rvalid0_d = c0_gnt & ~c0_we;
        rvalid1_d = c1_gnt & ~c1_we;
        rdErr0_d  = ~inRange0;
        rdErr1_d  = ~inRange1;
        addrErr_d = addrErr_q | (c0_gnt & ~inRange0) | (c1_gnt & ~inRange1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lockOwner_q <= LOCK_NONE;
            lastGnt_q   <= 1'b1;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdErr0_q    <= 1'b0;
            rdErr1_q    <= 1'b0;
            addrErr_q   <= 1'b0;
        end else begin
            lockOwner_q <= lockOwner_d;
            lastGnt_q   <= lastGnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdErr0_q    <= rdErr0_d;
            rdErr1_q    <= rdErr1_d;
            addrErr_q   <= addrErr_d;
        end
    end

    assign sel0 = c0_gnt & inRange0;
    assign sel1 = c1_gnt & inRange1;

    assign mem_0_wr_en   = sel0 & c0_we;
    assign mem_0_rd_en   = sel0 & ~c0_we;
    assign mem_0_wr_addr = mem_0_wr_en ? c0_addr : '0;
    assign mem_0_rd_addr = mem_0_rd_en ? c0_addr : '0;
    assign mem_0_din     = mem_0_wr_en ? c0_din  : '0;
    assign mem_1_wr_en   = sel1 & c1_we;
    assign mem_1_rd_en   = sel1 & ~c1_we;
    assign mem_1_wr_addr = mem_1_wr_en ? c1_addr : '0;
    assign mem_1_rd_addr = mem_1_rd_en ? c1_addr : '0;
    assign mem_1_din     = mem_1_wr_en ? c1_din  : '0;

    // Returned data is masked to zero for out-of-range reads; everything reads 0 during reset.
    assign c0_rvalid = rvalid0_q & ~rst;
    assign c1_rvalid = rvalid1_q & ~rst;
    assign c0_rdata  = (c0_rvalid && !rdErr0_q) ? mem_dout : '0;
    assign c1_rdata  = (c1_rvalid && !rdErr1_q) ? mem_dout : '0;
    assign addr_err  = addrErr_q & ~rst;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] statGnt0_q, statGnt1_q, statConflict_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            statGnt0_q     <= '0;
            statGnt1_q     <= '0;
            statConflict_q <= '0;
        end else begin
            if (c0_gnt && statGnt0_q != '1) statGnt0_q <= statGnt0_q + 32'd1;
            if (c1_gnt && statGnt1_q != '1) statGnt1_q <= statGnt1_q + 32'd1;
            if (c0_req && c1_req && statConflict_q != '1) statConflict_q <= statConflict_q + 32'd1;
        end
    end

    assign stat_gnt0     = rst ? '0 : statGnt0_q;
    assign stat_gnt1     = rst ? '0 : statGnt1_q;
    assign stat_conflict = rst ? '0 : statConflict_q;
`endif

endmodule
